// File: rtl/md_pkg.sv
// Shared multiply/divide definitions: op encodings, default latencies,
// busy-counter width and the packed {hi,lo} result bundle.
package md_pkg;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MTHI  = 4'd5;
  localparam logic [3:0] MD_MTLO  = 4'd6;

  localparam int MD_MULT_CYCLES = 5;
  localparam int MD_DIV_CYCLES  = 10;
  localparam int MD_CNT_W       = 8;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } md_res_t;

endpackage

// File: rtl/md_busy_ctr.sv
// Loadable down-counter: busy while nonzero, done in the last busy cycle.
// Ports: clk, reset (async low), load, load_val -> busy, done.
module md_busy_ctr
  import md_pkg::*;
#(
  parameter int W = MD_CNT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         busy,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign busy = (cnt != '0);
  // Final busy cycle: the edge closing it moves 1->0 and commits HI/LO.
  assign done = (cnt == W'(1));

endmodule

// File: rtl/md_unit.sv
// Execute-stage mult/div unit owning HI/LO, with busy-counter latency.
// Ports: clk, reset, E_md_op, E_RD1, E_RD2, D_md_use -> start, busy,
// md_stall, HI, LO. Divide support is compiled only with MD_DIV_EN.
module md_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  E_md_op,
  input  logic [31:0] E_RD1,
  input  logic [31:0] E_RD2,
  input  logic        D_md_use,
  output logic        start,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  logic                is_mul;
  logic                is_div;
  logic                done;
  logic [63:0]         ext_a;
  logic [63:0]         ext_b;
  logic [63:0]         prod;
  logic [MD_CNT_W-1:0] load_val;
  md_res_t             res;
  md_res_t             pend;

  always_comb begin
    is_mul = (E_md_op == MD_MULT) || (E_md_op == MD_MULTU);
`ifdef MD_DIV_EN
    is_div = (E_md_op == MD_DIV) || (E_md_op == MD_DIVU);
`else
    is_div = 1'b0;
`endif
  end

  assign start    = (is_mul | is_div) & ~busy;
  assign md_stall = D_md_use & (start | busy);
  assign load_val = is_mul ? MD_CNT_W'(MULT_CYCLES)
                           : MD_CNT_W'(DIV_CYCLES);

  // Low 64 bits of an extended product are exact for both signednesses.
  always_comb begin
    if (E_md_op == MD_MULT) begin
      ext_a = {{32{E_RD1[31]}}, E_RD1};
      ext_b = {{32{E_RD2[31]}}, E_RD2};
    end else begin
      ext_a = {32'd0, E_RD1};
      ext_b = {32'd0, E_RD2};
    end
    prod = ext_a * ext_b;
  end

`ifdef MD_DIV_EN
  logic        sgn;
  logic [31:0] ma;
  logic [31:0] mb;
  logic [31:0] uq;
  logic [31:0] ur;
  logic [31:0] q;
  logic [31:0] r;

  // Signed divide via magnitudes: no signed overflow on 0x80000000/-1.
  always_comb begin
    sgn = (E_md_op == MD_DIV);
    ma  = (sgn && E_RD1[31]) ? -E_RD1 : E_RD1;
    mb  = (sgn && E_RD2[31]) ? -E_RD2 : E_RD2;
    uq  = (mb == '0) ? '0 : ma / mb;
    ur  = (mb == '0) ? '0 : ma % mb;
    q   = (sgn && (E_RD1[31] ^ E_RD2[31])) ? -uq : uq;
    r   = (sgn && E_RD1[31]) ? -ur : ur;
  end
`endif

  always_comb begin
    res = {prod[63:32], prod[31:0]};
`ifdef MD_DIV_EN
    // Divide by zero still runs full latency but recommits old HI/LO.
    if (is_div) begin
      res = (E_RD2 == '0) ? {HI, LO} : {r, q};
    end
`endif
  end

  md_busy_ctr #(.W(MD_CNT_W)) u_ctr (
    .clk      (clk),
    .reset    (reset),
    .load     (start),
    .load_val (load_val),
    .busy     (busy),
    .done     (done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      HI   <= '0;
      LO   <= '0;
      pend <= '0;
    end else begin
      if (start) begin
        pend <= res;
      end
      if (done) begin
        HI <= pend.hi;
        LO <= pend.lo;
      end else if (!busy) begin
        unique case (E_md_op)
          MD_MTHI: HI <= E_RD1;
          MD_MTLO: LO <= E_RD1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: vector table, corner sequences,
// and random ops against an arithmetic HI/LO reference model.
module tb_md_unit;

`ifdef MD_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif
  localparam int NM = 5;
  localparam int ND = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  E_md_op;
  logic [31:0] E_RD1;
  logic [31:0] E_RD2;
  logic        D_md_use;
  logic        start;
  logic        busy;
  logic        md_stall;
  logic [31:0] HI;
  logic [31:0] LO;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  md_unit #(.MULT_CYCLES(NM), .DIV_CYCLES(ND)) dut (
    .clk      (clk),
    .reset    (reset),
    .E_md_op  (E_md_op),
    .E_RD1    (E_RD1),
    .E_RD2    (E_RD2),
    .D_md_use (D_md_use),
    .start    (start),
    .busy     (busy),
    .md_stall (md_stall),
    .HI       (HI),
    .LO       (LO)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset && busy && E_md_op >= 4'd1 && E_md_op <= 4'd6) begin
      miscompares++;
      $display("FAIL op_while_busy: op %0d presented while busy", E_md_op);
    end
  end

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Architectural reference: what HI/LO become and how long it takes.
  task automatic model(input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, output bit acc,
                       output int n, output logic [31:0] nh,
                       output logic [31:0] nl);
    longint sa, sb, q, r;
    logic [63:0] p;
    nh = m_hi; nl = m_lo; acc = 1'b0; n = 0;
    case (op)
      4'd1: begin
        p = longint'($signed(a)) * longint'($signed(b));
        acc = 1'b1; n = NM; nh = p[63:32]; nl = p[31:0];
      end
      4'd2: begin
        p = longint'({32'd0, a}) * longint'({32'd0, b});
        acc = 1'b1; n = NM; nh = p[63:32]; nl = p[31:0];
      end
      4'd3, 4'd4: begin
        if (DIV_EN) begin
          acc = 1'b1; n = ND;
          if (b != 0) begin
            sa = (op == 4'd3) ? longint'($signed(a)) : longint'({32'd0, a});
            sb = (op == 4'd3) ? longint'($signed(b)) : longint'({32'd0, b});
            q = sa / sb;
            r = sa % sb;
            nl = q[31:0];
            nh = r[31:0];
          end
        end
      end
      4'd5: nh = a;
      4'd6: nl = a;
      default: ;
    endcase
  endtask

  task automatic apply(input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic use_d);
    bit acc;
    int n, cyc;
    logic [31:0] nh, nl;
    model(op, a, b, acc, n, nh, nl);
    E_md_op = op; E_RD1 = a; E_RD2 = b; D_md_use = use_d;
    #1;
    check("start", start, acc);
    check("stall_start", md_stall, use_d & acc);
    step();
    E_md_op = 4'd0;
    cyc = 0;
    while (busy && cyc < n + 3) begin
      #1;
      if (md_stall !== use_d) begin
        check("stall_busy", md_stall, use_d);
      end
      if (HI !== m_hi || LO !== m_lo) begin
        check("hilo_busy", {HI, LO}, {m_hi, m_lo});
      end
      cyc++;
      step();
    end
    check("busy_cycles", cyc, n);
    m_hi = nh; m_lo = nl;
    check("hilo", {HI, LO}, {m_hi, m_lo});
    check("stall_after", md_stall, 1'b0);
    D_md_use = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        use_d;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic [31:0] ph, pl, eh, el;
    logic [3:0] rop;
    logic [31:0] ra, rb;
    bit is_d;

    tbl[0] = '{4'd1, 32'hFFFFFFFE, 32'h3, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFA};
    tbl[1] = '{4'd2, 32'hFFFFFFFE, 32'h3, 1'b0, 32'h2, 32'hFFFFFFFA};
    tbl[2] = '{4'd3, 32'hFFFFFFF9, 32'h2, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD};
    tbl[3] = '{4'd4, 32'h7, 32'h2, 1'b0, 32'h1, 32'h3};
    tbl[4] = '{4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h0, 32'h80000000};
    tbl[5] = '{4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFE, 32'h1};

    reset = 1'b0; E_md_op = 4'd0; E_RD1 = '0; E_RD2 = '0; D_md_use = 1'b0;
    #12;
    check("rst_busy", busy, 1'b0);
    check("rst_hilo", {HI, LO}, 64'd0);
    E_md_op = 4'd1; D_md_use = 1'b1;
    #1;
    check("rst_start", start, 1'b1);
    check("rst_stall", md_stall, 1'b1);
    E_md_op = 4'd0; D_md_use = 1'b0;
    step();
    reset = 1'b1;
    step();

    for (int i = 0; i < 6; i++) begin
      ph = m_hi; pl = m_lo;
      apply(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].use_d);
      is_d = (tbl[i].op == 4'd3) || (tbl[i].op == 4'd4);
      eh = (is_d && !DIV_EN) ? ph : tbl[i].hi;
      el = (is_d && !DIV_EN) ? pl : tbl[i].lo;
      check($sformatf("tbl%0d", i), {HI, LO}, {eh, el});
    end

    apply(4'd5, 32'h12345678, 32'h0, 1'b0);
    check("mthi", HI, 32'h12345678);
    apply(4'd5, 32'h1, 32'h0, 1'b0);
    apply(4'd6, 32'h2, 32'h0, 1'b0);
    apply(4'd3, 32'h5, 32'h0, 1'b1);
    check("div0", {HI, LO}, {32'h1, 32'h2});

    // Reset in the third busy cycle of a long op.
    rop = DIV_EN ? 4'd3 : 4'd1;
    E_md_op = rop; E_RD1 = 32'd100; E_RD2 = 32'd7; D_md_use = 1'b1;
    step();
    E_md_op = 4'd0;
    step();
    step();
    #2;
    reset = 1'b0;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_hilo", {HI, LO}, 64'd0);
    check("arst_stall", md_stall, 1'b0);
    m_hi = '0; m_lo = '0;
    step();
    reset = 1'b1;
    D_md_use = 1'b0;
    step();
    apply(4'd1, 32'd6, 32'd7, 1'b1);
    check("post_rst", {HI, LO}, {32'd0, 32'd42});

    for (int i = 0; i < 40; i++) begin
      rop = 4'($urandom_range(1, 6));
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = 32'hFFFFFFFF;
      apply(rop, ra, rb, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
